// File: rtl/sd_pkg.sv
// Shared types and constants for the SD multi-block read path.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_RECV,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } sd_mbr_state_t;

  localparam logic [1:0] SD_ERR_NONE    = 2'b00;
  localparam logic [1:0] SD_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] SD_ERR_OVERRUN = 2'b10;

  localparam int SD_BLOCK_BYTES = 512;

endpackage

// File: rtl/sd_byte_fifo.sv
// Synchronous first-word fall-through FIFO with a synchronous flush.
module sd_byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/sd_multiblock_reader.sv
// Streams consecutive SD blocks from sd_controller into a byte-wide valid/ready stream.
module sd_multiblock_reader
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES    = SD_BLOCK_BYTES,
  parameter int CNT_W          = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk_spi,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      start_block,
  input  logic [CNT_W-1:0] block_count,
  output logic [31:0]      sdc_address,
  output logic             sdc_rd,
  input  logic             sdc_ready,
  input  logic [7:0]       sdc_dout,
  input  logic             sdc_byte_available,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_block_last,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output sd_mbr_state_t    state_dbg
);

  localparam int BW  = $clog2(BLOCK_BYTES);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW1 = $clog2(FIFO_DEPTH) + 1;

  sd_mbr_state_t    state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] blocks_left_q;
  logic [BW-1:0]    byte_cnt_q;
  logic [TW-1:0]    to_q;
  logic             rd_q, busy_q, done_q, error_q;
  logic [1:0]       err_q;
  logic             bav_s1_q, bav_s2_q;
  logic [7:0]       dout_q;

  logic             capture, pop, push, flush, overrun, timeout;
  logic             blk_last, xfer_last, fifo_empty, fifo_full;
  logic [9:0]       fifo_dout;
  logic [AW1-1:0]   fifo_count;

  // Handshake: a byte moves when m_valid && m_ready at a clock edge; while m_valid
  // is high and m_ready low, m_data/m_block_last/m_last hold the same FIFO head.
  assign capture   = bav_s1_q && !bav_s2_q && (state_q == S_RECV);
  assign pop       = !fifo_empty && m_ready;
  assign overrun   = capture && fifo_full && !pop;
  assign push      = capture && !overrun;
  assign blk_last  = &byte_cnt_q;
  assign xfer_last = blk_last && (blocks_left_q == CNT_W'(1));
  assign timeout   = (((state_q == S_WAIT_RDY) && !sdc_ready) ||
                      ((state_q == S_RECV) && !capture)) &&
                     (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign flush     = overrun || timeout || (state_q == S_ERROR);

  sd_byte_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_spi),
    .rst_n (reset_n),
    .flush (flush),
    .push  (push),
    .din   ({dout_q, blk_last, xfer_last}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk_spi or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      blocks_left_q <= '0;
      byte_cnt_q    <= '0;
      to_q          <= '0;
      rd_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_q         <= SD_ERR_NONE;
      bav_s1_q      <= 1'b0;
      bav_s2_q      <= 1'b0;
      dout_q        <= '0;
    end else begin
      bav_s1_q <= sdc_byte_available;
      bav_s2_q <= bav_s1_q;
      dout_q   <= sdc_dout;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      if ((state_q == S_WAIT_RDY) || (state_q == S_RECV)) to_q <= to_q + TW'(1);

      if (overrun || timeout) begin
        state_q <= S_ERROR;
        error_q <= 1'b1;
        busy_q  <= 1'b0;
        err_q   <= overrun ? SD_ERR_OVERRUN : SD_ERR_TIMEOUT;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              addr_q        <= start_block;
              blocks_left_q <= block_count;
              err_q         <= SD_ERR_NONE;
              error_q       <= 1'b0;
              byte_cnt_q    <= '0;
              to_q          <= '0;
              if (block_count == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_WAIT_RDY;
                busy_q  <= 1'b1;
              end
            end
          end
          S_WAIT_RDY: if (sdc_ready) state_q <= S_ISSUE;
          S_ISSUE: begin
            rd_q    <= 1'b1;
            to_q    <= '0;
            state_q <= S_RECV;
          end
          S_RECV: begin
            if (capture) begin
              byte_cnt_q <= byte_cnt_q + BW'(1);
              to_q       <= '0;
              if (blk_last) begin
                blocks_left_q <= blocks_left_q - CNT_W'(1);
                addr_q        <= addr_q + 32'd1;
                state_q       <= xfer_last ? S_DRAIN : S_WAIT_RDY;
              end
            end
          end
          S_DRAIN: begin
            // Finish on the edge of the final pop so done follows it by one cycle.
            if (fifo_empty || ((fifo_count == AW1'(1)) && pop)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sdc_address  = addr_q;
  assign sdc_rd       = rd_q;
  assign m_valid      = !fifo_empty;
  assign m_data       = m_valid ? fifo_dout[9:2] : 8'h00;
  assign m_block_last = m_valid && fifo_dout[1];
  assign m_last       = m_valid && fifo_dout[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sd_multiblock_reader.sv
// Scoreboarded bench for sd_multiblock_reader with a behavioural SD controller model.
module tb_sd_multiblock_reader;
  import sd_pkg::*;

  localparam int TO = 100;

  logic          clk_spi = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_block = '0;
  logic [15:0]   block_count = '0;
  logic [31:0]   sdc_address;
  logic          sdc_rd;
  logic          sdc_ready = 1'b1;
  logic [7:0]    sdc_dout = '0;
  logic          sdc_byte_available = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_block_last, m_last, busy, done, error;
  logic [1:0]    err_code;
  sd_mbr_state_t state_dbg;

  sd_multiblock_reader #(
    .BLOCK_BYTES(512), .CNT_W(16), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_spi(clk_spi), .reset_n(reset_n), .start(start), .start_block(start_block),
    .block_count(block_count), .sdc_address(sdc_address), .sdc_rd(sdc_rd),
    .sdc_ready(sdc_ready), .sdc_dout(sdc_dout), .sdc_byte_available(sdc_byte_available),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_block_last(m_block_last),
    .m_last(m_last), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk_spi = ~clk_spi;
  int cyc = 0;
  always @(posedge clk_spi) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [9:0]  exp_q[$];
  logic [31:0] addr_q[$];
  int ready_mode = 1;
  int last_pop_cyc = -1;
  int rd_count = 0;
  int ctrl_force_nr = 0, ctrl_abort = 0, ctrl_slow = 0, ctrl_busy = 0;
  int ctrl_blocks = 0, ctrl_bytes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Block contents as stored on the card model.
  function automatic logic [7:0] sd_byte(input logic [31:0] a, input int i);
    logic [7:0] r;
    r = a[7:0] * 8'd31 + a[15:8] + 8'(i) + ((i >= 256) ? 8'd101 : 8'd0);
    return r;
  endfunction

  // Reference model: a transfer is n blocks of 512 bytes from sb, sb+1, ...
  task automatic model_push(input logic [31:0] sb, input int n);
    for (int b = 0; b < n; b++) begin
      addr_q.push_back(sb + 32'(b));
      for (int i = 0; i < 512; i++)
        exp_q.push_back({sd_byte(sb + 32'(b), i), i == 511, (b == n - 1) && (i == 511)});
    end
  endtask

  // ---------------- consumer + byte monitor ----------------
  always @(negedge clk_spi) begin
    logic [9:0] e;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) note_fail("unexpected_byte");
      else begin
        e = exp_q.pop_front();
        check("byte", 32'({m_data, m_block_last, m_last}), 32'(e));
        if (e[0]) last_pop_cyc = cyc;
      end
    end
  end

  // ---------------- read-command monitor ----------------
  always @(negedge clk_spi) begin
    if (sdc_rd) begin
      rd_count++;
      if (addr_q.size() == 0) note_fail("unexpected_sdc_rd");
      else check("rd_addr", sdc_address, addr_q.pop_front());
    end
  end

  // ---------------- SD controller model ----------------
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk_spi);
      sdc_ready = (ctrl_force_nr == 0);
      if (sdc_rd && ctrl_force_nr == 0) begin
        ctrl_busy = 1;
        sdc_ready = 1'b0;
        a = sdc_address;
        ctrl_blocks++;
        ctrl_bytes = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk_spi);
        for (int i = 0; i < 512 && ctrl_abort == 0; i++) begin
          sdc_dout = sd_byte(a, i);
          sdc_byte_available = 1'b1;
          ctrl_bytes = i + 1;
          repeat (ctrl_slow != 0 ? 2 : $urandom_range(1, 2)) @(negedge clk_spi);
          sdc_byte_available = 1'b0;
          repeat (ctrl_slow != 0 ? 2 : $urandom_range(2, 3)) @(negedge clk_spi);
        end
        sdc_byte_available = 1'b0;
        sdc_ready = (ctrl_force_nr == 0);
        ctrl_busy = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] sb, input int n, output int c0);
    @(negedge clk_spi);
    start_block = sb;
    block_count = 16'(n);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk_spi);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output logic seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int k = 0; k < budget; k++) begin
      if (done || error) begin
        seen = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk_spi);
    end
  endtask

  task automatic wait_ctrl_idle(input int budget);
    int k;
    k = 0;
    while (ctrl_busy != 0 && k < budget) begin
      @(negedge clk_spi);
      k++;
    end
    check("ctrl_idle", 32'(ctrl_busy), 32'd0);
  endtask

  task automatic run_xfer(input string name, input logic [31:0] sb, input int n,
                          input int mode, output int done_cyc);
    int c0;
    logic seen;
    model_push(sb, n);
    ready_mode = mode;
    do_start(sb, n, c0);
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_err_clr"}, 32'({error, err_code}), 32'd0);
    wait_end(4000 * n + 500, seen, done_cyc);
    check({name, "_done_seen"}, 32'({seen, done, error}), 32'b110);
    check({name, "_left_bytes"}, 32'(exp_q.size()), 32'd0);
    check({name, "_left_reads"}, 32'(addr_q.size()), 32'd0);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    @(negedge clk_spi);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0, at, rc, base;
    logic seen;

    #1;
    check("rst_outputs", 32'({sdc_address != 0, sdc_rd, m_valid, m_data != 0, m_block_last,
                              m_last, busy, done, error, err_code}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    repeat (3) @(negedge clk_spi);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_spi);

    // single block, consumer always ready
    run_xfer("single", 32'h100, 1, 1, at);
    check("single_done_lat", 32'(at - last_pop_cyc), 32'd1);
    wait_ctrl_idle(100);

    // three blocks with 50% backpressure
    run_xfer("multi", 32'h100, 3, 2, at);
    wait_ctrl_idle(100);

    // zero blocks
    rc = rd_count;
    do_start(32'h700, 0, c0);
    wait_end(3, seen, at);
    check("zero_done", 32'({seen, done}), 32'b11);
    check("zero_done_lat", 32'((at - c0) <= 2), 32'd1);
    repeat (10) @(negedge clk_spi);
    check("zero_no_rd", 32'(rd_count - rc), 32'd0);

    // overrun: consumer stalled, FIFO holds 16, byte 17 overflows
    ctrl_slow = 1;
    model_push(32'h200, 1);
    ready_mode = 0;
    do_start(32'h200, 1, c0);
    wait_end(1000, seen, at);
    check("ovr_seen", 32'({seen, error}), 32'b11);
    check("ovr_code", 32'(err_code), 32'(SD_ERR_OVERRUN));
    check("ovr_flushed", 32'(m_valid), 32'd0);
    check("ovr_byte_idx", 32'(ctrl_bytes), 32'd17);
    check("ovr_busy", 32'(busy), 32'd0);
    wait_ctrl_idle(3000);
    exp_q.delete();
    ctrl_slow = 0;
    repeat (5) @(negedge clk_spi);
    check("ovr_err_held", 32'({error, err_code}), 32'b110);

    // timeout with the controller never ready
    ctrl_force_nr = 1;
    repeat (3) @(negedge clk_spi);
    rc = rd_count;
    do_start(32'h300, 1, c0);
    wait_end(TO + 50, seen, at);
    check("to_seen", 32'({seen, error}), 32'b11);
    check("to_code", 32'(err_code), 32'(SD_ERR_TIMEOUT));
    check("to_latency", 32'(at - c0), 32'(TO + 1));
    check("to_no_rd", 32'(rd_count - rc), 32'd0);
    ctrl_force_nr = 0;
    repeat (3) @(negedge clk_spi);
    run_xfer("after_to", 32'h300, 1, 1, at);
    wait_ctrl_idle(100);

    // asynchronous reset in block 2 at byte 200
    base = ctrl_blocks;
    model_push(32'h400, 3);
    ready_mode = 2;
    do_start(32'h400, 3, c0);
    for (int k = 0; k < 6000 && !(ctrl_blocks == base + 2 && ctrl_bytes >= 200); k++)
      @(negedge clk_spi);
    check("rst_reach_b2", 32'(ctrl_blocks == base + 2 && ctrl_bytes >= 200), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({sdc_address != 0, sdc_rd, m_valid, m_data != 0, m_block_last,
                                 m_last, busy, done, error, err_code}), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    ctrl_abort = 1;
    exp_q.delete();
    addr_q.delete();
    wait_ctrl_idle(50);
    ctrl_abort = 0;
    repeat (3) @(negedge clk_spi);
    reset_n = 1'b1;
    rc = rd_count;
    repeat (20) @(negedge clk_spi);
    check("post_rst_no_rd", 32'(rd_count - rc), 32'd0);
    run_xfer("post_rst", 32'h500, 1, 1, at);
    wait_ctrl_idle(100);

    // randomized transfers, first one crosses the 32-bit address wrap
    for (int t = 0; t < 3; t++) begin
      logic [31:0] sb;
      sb = (t == 0) ? 32'hFFFF_FFFF : $urandom;
      run_xfer("rand", sb, (t == 0) ? 2 : $urandom_range(1, 2), $urandom_range(1, 2), at);
      wait_ctrl_idle(100);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_multiblock_reader.md
# sd_multiblock_reader

Streams `block_count` consecutive 512-byte SD blocks, starting at `start_block`, to a byte-wide valid/ready consumer. It drives the existing `sd_controller` command side (address, rd) and buffers its bytes in an internal FIFO. Unlike the single-block array reader, it adds:
- consumer backpressure,
- per-block and end-of-transfer markers,
- a response timeout,
- overrun detection.

It sits between `sd_controller` and pattern/board loaders in the `clk_spi` domain.

## Interface
- `BLOCK_BYTES`, 512: bytes per block; power of two.
- `CNT_W`, 16: width of `block_count`.
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1_000_000: max idle cycles waiting for `sdc_ready` or the next byte.

Ports (name, direction, width, meaning):
- `clk_spi` in 1: clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE, DONE or ERROR.
- `start_block` in 32: first block address, captured on `start`.
- `block_count` in CNT_W: number of blocks, captured on `start`.
- `sdc_address` out 32: block address to `sd_controller`.
- `sdc_rd` out 1: one-cycle read pulse to `sd_controller`.
- `sdc_ready` in 1: controller idle.
- `sdc_dout` in 8: read byte.
- `sdc_byte_available` in 1: byte strobe; level may last several cycles.
- `m_data` out 8: FIFO head byte.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head byte.
- `m_block_last` out 1: head byte is byte `BLOCK_BYTES-1` of its block.
- `m_last` out 1: head byte is the final byte of the transfer.
- `busy` out 1: high from the accepted `start` until DONE or ERROR.
- `done` out 1: one-cycle pulse on entering DONE.
- `error` out 1: high in ERROR.
- `err_code` out 2: 01 = timeout, 10 = overrun; 00 otherwise.

## Operation
- **States:** IDLE, WAIT_RDY, ISSUE, RECV, DRAIN, DONE, ERROR.
- **Start:** IDLE/DONE/ERROR + `start`:
  - latch `start_block` → `sdc_address`, `block_count` → `blocks_left`;
  - clear `err_code` and the byte counter;
  - `block_count==0` → DONE, otherwise → WAIT_RDY.
- **WAIT_RDY:** `sdc_ready` → ISSUE.
- **ISSUE:** assert `sdc_rd` for exactly one cycle, then → RECV.
- **Byte capture:** a byte is captured on the rising edge of `sdc_byte_available` (registered edge detect), never on its level.
  - Each capture pushes {`sdc_dout`, block_last, last} into the FIFO and increments the byte counter mod `BLOCK_BYTES`.
- **RECV → next state:** when the counter wraps to 0:
  - decrement `blocks_left` and increment `sdc_address` (mod 2^32);
  - if `blocks_left` was 1 → DRAIN, else → WAIT_RDY.
- **DRAIN:** wait for FIFO empty, then → DONE.
- **Consumer side:** a pop happens when `m_valid && m_ready`.
- **Overrun:** capture with FIFO full and no simultaneous pop → drop the byte, `err_code`=10, → ERROR.
  - Capture and pop in the same cycle with FIFO full is legal.
- **Timeout:** counter cleared on entry to WAIT_RDY/RECV and on every capture. Reaching `TIMEOUT_CYCLES` → `err_code`=01, → ERROR.
- **ERROR:**
  - FIFO is flushed;
  - `error` is held;
  - `sdc_rd` stays 0 until the next `start`.
- **`start` while `busy`:** ignored.

## Timing
- **Reset values:** `sdc_address`=0, `sdc_rd`=0, `m_valid`=0, `m_data`=0, `m_block_last`=0, `m_last`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0; FIFO empty; state IDLE.
- **Reset mid-transfer:** immediate return to all reset values. No further `sdc_rd` until a new `start`.
- **`busy`:** rises the cycle after `start` and falls the cycle `done` or `error` rises.
- **`sdc_rd`:** asserted the cycle after entering ISSUE, i.e. ≥2 cycles after `start` when `sdc_ready` is already high.
- **First-word fall-through FIFO:** `m_valid` rises 2 cycles after the `sdc_byte_available` rising edge (1 edge-detect register + 1 FIFO write).
- **Output stability:** `m_data`, `m_block_last` and `m_last` are stable while `m_valid && !m_ready`.
- **`done`:** pulses the cycle after the final pop.
- **Arithmetic:** byte counter is log2(`BLOCK_BYTES`) bits; `blocks_left` is CNT_W bits; the address increment wraps at 0xFFFF_FFFF.

## Structure
- **Shared package `sd_pkg`:**
  - the state enum `sd_mbr_state_t`;
  - the `err_code` constants `SD_ERR_NONE`, `SD_ERR_TIMEOUT`, `SD_ERR_OVERRUN`;
  - `SD_BLOCK_BYTES`=512.
- **Sub-module `sd_byte_fifo`:**
  - parametrised sync FIFO, width 10 (data + 2 flags), depth `FIFO_DEPTH`;
  - first-word fall-through, with a flush input.
- **Top level:** FSM, counters, edge detect and timeout counter.

## Test plan
- **Single block:** `start_block`=0x100, `block_count`=1, `m_ready`=1.
  - Expect one `sdc_rd` with `sdc_address`=0x100.
  - Expect 512 bytes out in order; `m_block_last` and `m_last` on byte 511; `done` 1 cycle later.
- **Multi-block with backpressure:** `block_count`=3, `m_ready` toggling 50%.
  - Expect reads at 0x100, 0x101, 0x102 and 1536 bytes out.
  - Expect `m_block_last` on bytes 511, 1023 and 1535; `m_last` only on 1535.
- **Zero count:** `block_count`=0.
  - Expect no `sdc_rd`, and `done` within 2 cycles of `start`.
- **Overrun:** `m_ready`=0 with `FIFO_DEPTH`=16.
  - Byte 17 → `err_code`=10, `error`=1, `m_valid`=0.
- **Timeout:** `TIMEOUT_CYCLES`=100 and `sdc_ready` held 0.
  - `err_code`=01 after 100 cycles in WAIT_RDY.
  - A following `start` clears the error and the next read completes.
- **Async reset:** drop `reset_n` mid-block 2 at byte 200.
  - All outputs return to reset values immediately.
  - A new `start` reads from the new `start_block`.
